// File: rtl/npu_dsp_pkg.sv
// Shared types for the NPU DSP lane responder (dsp_mac_array).
// Widths of operands, products and accumulators; window FSM states.
package npu_dsp_pkg;

  localparam int DSP_IN_W   = 18;
  localparam int DSP_OUT_W  = 37;
  localparam int DSP_PROD_W = 2 * DSP_IN_W;

  typedef logic [DSP_IN_W-1:0]   dsp_op_t;
  typedef logic [DSP_OUT_W-1:0]  dsp_acc_t;
  typedef logic [DSP_PROD_W-1:0] dsp_prod_t;

  typedef enum logic {
    WIN_IDLE,
    WIN_ACCUM
  } win_state_t;

endpackage

// File: rtl/dsp_mac_lane.sv
// One MAC lane: operand regs, product reg, 37-bit accumulator, sticky ovf.
// Build with DSP_ACC_SAT_EN to saturate on carry-out instead of wrapping.
module dsp_mac_lane
  import npu_dsp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 ce_i,
  input  logic                 v2_i,
  input  logic                 fresh_i,
  input  logic [DSP_IN_W-1:0]  a_i,
  input  logic [DSP_IN_W-1:0]  b_i,
  output logic [DSP_OUT_W-1:0] acc_o,
  output logic                 ovf_o
);

  dsp_op_t              a_q, b_q;
  dsp_prod_t            prod_q;
  dsp_acc_t             acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [DSP_OUT_W:0]   sum_w;
`ifdef DSP_ACC_SAT_EN
  logic                 sat_q, sat_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
    end else if (clr_i) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
    end else begin
      if (ce_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      prod_q <= dsp_prod_t'(a_q) * dsp_prod_t'(b_q);
    end
  end

  // Top bit of the 38-bit sum is the carry out of bit 36
  assign sum_w = {1'b0, acc_q} + (DSP_OUT_W+1)'(prod_q);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
`ifdef DSP_ACC_SAT_EN
    sat_d = sat_q;
`endif
    if (v2_i) begin
      if (fresh_i) begin
        acc_d = dsp_acc_t'(prod_q);
`ifdef DSP_ACC_SAT_EN
        sat_d = 1'b0;
`endif
      end
`ifdef DSP_ACC_SAT_EN
      else if (sat_q) begin
        acc_d = acc_q;
      end
`endif
      else if (sum_w[DSP_OUT_W]) begin
        ovf_d = 1'b1;
`ifdef DSP_ACC_SAT_EN
        acc_d = '1;
        sat_d = 1'b1;
`else
        acc_d = sum_w[DSP_OUT_W-1:0];
`endif
      end else begin
        acc_d = sum_w[DSP_OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
`ifdef DSP_ACC_SAT_EN
      sat_q <= 1'b0;
`endif
    end else if (clr_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
`ifdef DSP_ACC_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
`ifdef DSP_ACC_SAT_EN
      sat_q <= sat_d;
`endif
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/dsp_mac_array.sv
// LANES-wide MAC array with shared valid pipe, beat counter and window FSM.
// Optional macro DSP_ACC_SAT_EN selects saturating accumulation in each lane.
module dsp_mac_array
  import npu_dsp_pkg::*;
#(
  parameter int LANES = 16,
  parameter int K_LEN = 32,
  parameter int CNT_W = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dsp_ce,
  input  logic [LANES-1:0][DSP_IN_W-1:0]  dsp_a0,
  input  logic [LANES-1:0][DSP_IN_W-1:0]  dsp_b0,
  input  logic                            acc_clr,
  output logic [LANES-1:0][DSP_OUT_W-1:0] dsp_out,
  output logic                            win_done,
  output logic [CNT_W-1:0]                beat_cnt,
  output logic                            ovf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(K_LEN - 1);

  logic             v1_q, v2_q;
  win_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             fresh_w;
  logic [LANES-1:0] lane_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (acc_clr) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= dsp_ce;
      v2_q <= v1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WIN_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (acc_clr) begin
      state_q <= WIN_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (v2_q) begin
        if (cnt_q == LAST) begin
          cnt_q   <= '0;
          done_q  <= 1'b1;
          state_q <= WIN_IDLE;
        end else begin
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= WIN_ACCUM;
        end
      end
    end
  end

  // IDLE coincides with beat_cnt==0: next product opens a fresh window
  assign fresh_w = (state_q == WIN_IDLE);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dsp_mac_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (acc_clr),
      .ce_i    (dsp_ce),
      .v2_i    (v2_q),
      .fresh_i (fresh_w),
      .a_i     (dsp_a0[g]),
      .b_i     (dsp_b0[g]),
      .acc_o   (dsp_out[g]),
      .ovf_o   (lane_ovf[g])
    );
  end

  assign win_done = done_q;
  assign beat_cnt = cnt_q;
  assign ovf      = |lane_ovf;

endmodule
